// File: rtl/cpu_pkg.sv
// cpu_pkg: shared PC-source encodings, opcode constants and reset PC default
package cpu_pkg;
    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_HOLD   = 2'b11
    } pcsrc_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pc_ir_unit_if.sv
// pc_ir_unit_if: controller strobes, ALU/memory buses and decoded IR fields
interface pc_ir_unit_if;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        Zero;
    logic [1:0]  PCSource;
    logic        IorD;
    logic        IRWrite;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [31:0] mdr;
    logic [31:0] alu_out;
    logic [31:0] fetch_count;
    logic        misalign_err;

    modport master (
        output PCWrite, PCWriteCond, Zero, PCSource, IorD, IRWrite, alu_result, mem_rdata,
        input  mem_addr, pc, instr, opcode, funct, rs, rt, rd, shamt, imm16, mdr, alu_out,
               fetch_count, misalign_err
    );

    modport slave (
        input  PCWrite, PCWriteCond, Zero, PCSource, IorD, IRWrite, alu_result, mem_rdata,
        output mem_addr, pc, instr, opcode, funct, rs, rt, rd, shamt, imm16, mdr, alu_out,
               fetch_count, misalign_err
    );
endinterface

// File: rtl/pc_ir_unit_en_reg.sv
// en_reg: parameterised-width register with async active-high reset and load enable
module en_reg #(
    parameter int          W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // load d when enabled, jump to the reset value immediately on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= RST_VAL;
        else if (en) q <= d;
    end
endmodule

// File: rtl/pc_ir_unit.sv
// pc_ir_unit: PC/IR/MDR/ALUOut register block of the multi-cycle MIPS datapath
// Optional PC_ALIGN_CHECK_EN: refuse misaligned PC loads and raise sticky misalign_err.
module pc_ir_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic         clk,
    input logic         reset,
    pc_ir_unit_if.slave bus
);
    logic [XLEN-1:0] pc_q, ir_q, mdr_q, alu_out_q, fc_q, next_pc;
    logic            pc_en, pc_ld;

    // next-PC select; the jump target uses the already-incremented PC
    always_comb begin
        pc_en   = bus.PCWrite | (bus.PCWriteCond & bus.Zero);
        next_pc = bus.PCSource == PCSRC_ALU    ? bus.alu_result :
                  bus.PCSource == PCSRC_ALUOUT ? alu_out_q :
                  bus.PCSource == PCSRC_JUMP   ? {pc_q[31:28], ir_q[25:0], 2'b00} : pc_q;
`ifdef PC_ALIGN_CHECK_EN
        pc_ld   = pc_en & (next_pc[1:0] == 2'b00);
`else
        pc_ld   = pc_en;
`endif
    end

    en_reg #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .reset(reset), .en(pc_ld), .d(next_pc), .q(pc_q));

    en_reg #(.W(XLEN)) u_ir (
        .clk(clk), .reset(reset), .en(bus.IRWrite), .d(bus.mem_rdata), .q(ir_q));

    en_reg #(.W(XLEN)) u_mdr (
        .clk(clk), .reset(reset), .en(1'b1), .d(bus.mem_rdata), .q(mdr_q));

    en_reg #(.W(XLEN)) u_alu_out (
        .clk(clk), .reset(reset), .en(1'b1), .d(bus.alu_result), .q(alu_out_q));

    en_reg #(.W(XLEN)) u_fetch_count (
        .clk(clk), .reset(reset), .en(bus.IRWrite), .d(fc_q + XLEN'(1)), .q(fc_q));

`ifdef PC_ALIGN_CHECK_EN
    logic err_q;
    // sticky misaligned-load flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else if (pc_en && next_pc[1:0] != 2'b00) err_q <= 1'b1;
    end
    assign bus.misalign_err = err_q;
`else
    assign bus.misalign_err = 1'b0;
`endif

    assign bus.mem_addr    = bus.IorD ? alu_out_q : pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = ir_q;
    assign bus.opcode      = ir_q[31:26];
    assign bus.rs          = ir_q[25:21];
    assign bus.rt          = ir_q[20:16];
    assign bus.rd          = ir_q[15:11];
    assign bus.shamt       = ir_q[10:6];
    assign bus.funct       = ir_q[5:0];
    assign bus.imm16       = ir_q[15:0];
    assign bus.mdr         = mdr_q;
    assign bus.alu_out     = alu_out_q;
    assign bus.fetch_count = fc_q;
endmodule
